// File: rtl/exe_stage.sv
// Execute stage: ALU, iterative signed multiply/divide with HI/LO, and the EX/MEM register.
// The multiply/divide unit holds the front of the pipeline while it iterates.
module exe_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [3:0]  ealuc,
    input  logic        ealuimm,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic [31:0] eimm,
    input  logic [4:0]  ern0,
    input  logic        eshift,
    input  logic        ejal,
    input  logic [31:0] epc4,
    input  logic [2:0]  emdop,
    output logic [4:0]  ern,
    output logic        stall,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [31:0] malu,
    output logic [31:0] mb,
    output logic [4:0]  mrn,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    // state | meaning
    // IDLE  | no mult/div in flight; a mult/div in EX latches operands
    // RUN   | one shift-add / shift-subtract step per cycle, count 0..31
    // DONE  | sign-correct and write HI/LO; stall released
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} md_state_t;

    md_state_t   state, state_nx;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div, neg_q, neg_r;

    logic        md_start;
    logic [31:0] op_a, op_b, alu_out, sra_out, result;
    logic [31:0] a_mag, b_mag;
    logic [32:0] msum, dshift, ddiff;
    logic        dfits;
    logic [63:0] step_nx, prod_fix;
    logic [31:0] q_fix, r_fix;

    assign md_start = (emdop == 3'b001) || (emdop == 3'b010);
    assign stall    = md_start && (state != DONE);
    assign ern      = ejal ? 5'd31 : ern0;

    assign op_a    = eshift ? {27'b0, eimm[10:6]} : ea;
    assign op_b    = ealuimm ? eimm : eb;
    assign sra_out = $signed(op_b) >>> op_a[4:0];

    always_comb begin
        alu_out = op_a + op_b;
        case (ealuc[2:0])
            3'b000: alu_out = op_a + op_b;
            3'b100: alu_out = op_a - op_b;
            3'b001: alu_out = op_a & op_b;
            3'b101: alu_out = op_a | op_b;
            3'b010: alu_out = op_a ^ op_b;
            3'b110: alu_out = op_b << 16;
            3'b011: alu_out = op_b << op_a[4:0];
            3'b111: alu_out = ealuc[3] ? sra_out : (op_b >> op_a[4:0]);
        endcase
    end

    always_comb begin
        result = alu_out;
        if (ejal)
            result = epc4 + 32'd4;
        else if (emdop == 3'b011)
            result = hi;
        else if (emdop == 3'b100)
            result = lo;
    end

    assign a_mag = ea[31] ? (32'd0 - ea) : ea;
    assign b_mag = eb[31] ? (32'd0 - eb) : eb;

    // Multiply keeps the multiplier in acc[31:0]; divide keeps {remainder, quotient} in acc.
    assign msum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign dshift  = {acc[63:32], acc[31]};
    assign ddiff   = dshift - {1'b0, opnd};
    assign dfits   = ~ddiff[32];
    assign step_nx = is_div ? (dfits ? {ddiff[31:0], acc[30:0], 1'b1}
                                     : {dshift[31:0], acc[30:0], 1'b0})
                            : {msum, acc[31:1]};

    assign prod_fix = neg_q ? (64'd0 - acc) : acc;
    assign q_fix    = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
    assign r_fix    = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (md_start) state_nx = RUN;
            RUN:     if (count == 5'd31) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= 5'd0;
            acc    <= 64'd0;
            opnd   <= 32'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        is_div <= (emdop == 3'b010);
                        neg_q  <= ea[31] ^ eb[31];
                        neg_r  <= ea[31];
                        count  <= 5'd0;
                        opnd   <= (emdop == 3'b010) ? b_mag : a_mag;
                        acc    <= {32'd0, (emdop == 3'b010) ? a_mag : b_mag};
                    end
                end
                RUN: begin
                    acc   <= step_nx;
                    count <= count + 5'd1;
                end
                DONE: begin
                    // Divide by zero leaves the dividend as remainder; quotient is forced to all ones.
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= (opnd == 32'd0) ? 32'hFFFF_FFFF : q_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || stall) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            malu   <= 32'd0;
            mb     <= 32'd0;
            mrn    <= 5'd0;
        end else begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            malu   <= result;
            mb     <= eb;
            mrn    <= ern;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage: ALU ops, shifts/jal, mult/div latency and results,
// reset behaviour and stall bubbles.
module tb_exe_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
    logic [3:0]  ealuc;
    logic [31:0] ea, eb, eimm, epc4;
    logic [4:0]  ern0;
    logic [2:0]  emdop;
    logic [4:0]  ern, mrn;
    logic        stall, mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb, hi, lo;

    int n_cmp = 0;
    int n_fail = 0;

    exe_stage dut (
        .clock(clock), .reset(reset),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealuc(ealuc), .ealuimm(ealuimm),
        .ea(ea), .eb(eb), .eimm(eimm), .ern0(ern0),
        .eshift(eshift), .ejal(ejal), .epc4(epc4), .emdop(emdop),
        .ern(ern), .stall(stall),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    localparam logic [3:0]  ALU_OP [8] = '{4'b0000, 4'b0001, 4'b0101, 4'b1010,
                                           4'b0110, 4'b0011, 4'b0111, 4'b1111};
    localparam logic [31:0] ALU_A  [8] = '{32'hFFFF_FFFF, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0,
                                           32'h0,         32'h4,         32'h4,         32'h24};
    localparam logic [31:0] ALU_B  [8] = '{32'h2,         32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00,
                                           32'h1234,      32'h1,         32'h8000_0000, 32'h8000_0000};
    localparam logic [31:0] ALU_E  [8] = '{32'h1,         32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0,
                                           32'h1234_0000, 32'h10,        32'h0800_0000, 32'hF800_0000};

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        ewreg = 0; em2reg = 0; ewmem = 0; ealuimm = 0; eshift = 0; ejal = 0;
        ealuc = 4'b0000; ea = 0; eb = 0; eimm = 0; epc4 = 0; ern0 = 0; emdop = 3'b000;
    endtask

    // Drives a mult/div into EX and steps until stall drops (DONE cycle).
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output int bad_bubbles);
        emdop = op; ea = a; eb = b; ewreg = 0;
        cycles = 0;
        bad_bubbles = 0;
        #1;
        while (stall === 1'b1 && cycles < 100) begin
            tick;
            cycles++;
            if (stall === 1'b1 && {mwreg, mwmem, mm2reg, malu, mrn} !== '0) bad_bubbles++;
        end
    endtask

    task automatic test_reset;
        idle_inputs;
        reset = 1;
        tick;
        tick;
        n_cmp++;
        if ({mwreg, mm2reg, mwmem, malu, mb, mrn} !== '0) begin
            n_fail++;
            $display("FAIL reset_exmem got %h expected 0", {mwreg, mm2reg, mwmem, malu, mb, mrn});
        end
        n_cmp++;
        if ({hi, lo, stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_hilo got hi=%h lo=%h stall=%b expected 0", hi, lo, stall);
        end
        reset = 0;
    endtask

    task automatic test_alu;
        idle_inputs;
        ea = 5; eb = 3; ealuc = 4'b0100; ern0 = 5'd7; ewreg = 1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_stall got %b expected 0", stall);
        end
        tick;
        n_cmp++;
        if (malu !== 32'd2 || mrn !== 5'd7 || mwreg !== 1'b1 || mb !== 32'd3) begin
            n_fail++;
            $display("FAIL alu_sub got malu=%h mrn=%0d mwreg=%b mb=%h expected 2/7/1/3", malu, mrn, mwreg, mb);
        end
        for (int i = 0; i < 8; i++) begin
            ealuc = ALU_OP[i]; ea = ALU_A[i]; eb = ALU_B[i];
            tick;
            n_cmp++;
            if (malu !== ALU_E[i]) begin
                n_fail++;
                $display("FAIL alu_op%0d got %h expected %h", i, malu, ALU_E[i]);
            end
        end
        ealuc = 4'b0000; ealuimm = 1; eimm = 32'h10; eb = 32'h999; ea = 1;
        tick;
        n_cmp++;
        if (malu !== 32'h11 || mb !== 32'h999) begin
            n_fail++;
            $display("FAIL alu_imm got malu=%h mb=%h expected 11/999", malu, mb);
        end
        ewmem = 1; em2reg = 1; ealuimm = 0; ea = 5; eb = 3; ern0 = 5'd12;
        reset = 1;
        tick;
        n_cmp++;
        if ({mwreg, mm2reg, mwmem, malu, mb, mrn} !== '0) begin
            n_fail++;
            $display("FAIL alu_midreset got %h expected 0", {mwreg, mm2reg, mwmem, malu, mb, mrn});
        end
        reset = 0;
    endtask

    task automatic test_shift_jal;
        idle_inputs;
        eshift = 1; eimm = 32'h0000_0100; ea = 32'h1F; eb = 32'h8000_0000; ealuc = 4'b1111;
        tick;
        n_cmp++;
        if (malu !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL shamt_sra got %h expected f8000000", malu);
        end
        idle_inputs;
        ejal = 1; epc4 = 32'h100; ern0 = 5'd5; ewreg = 1; emdop = 3'b100;
        #1;
        n_cmp++;
        if (ern !== 5'd31) begin
            n_fail++;
            $display("FAIL jal_ern got %0d expected 31", ern);
        end
        tick;
        n_cmp++;
        if (malu !== 32'h104 || mrn !== 5'd31) begin
            n_fail++;
            $display("FAIL jal_result got malu=%h mrn=%0d expected 104/31", malu, mrn);
        end
    endtask

    task automatic test_mult;
        int cyc, bad;
        idle_inputs;
        run_md(3'b001, 32'hFFFF_FFFE, 32'd3, cyc, bad);
        n_cmp++;
        if (cyc !== 33 || bad !== 0) begin
            n_fail++;
            $display("FAIL mult_stall got cycles=%0d bad_bubbles=%0d expected 33/0", cyc, bad);
        end
        tick;
        n_cmp++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA || mwreg !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_result got hi=%h lo=%h mwreg=%b expected ffffffff/fffffffa/0", hi, lo, mwreg);
        end
        idle_inputs;
        emdop = 3'b100; ewreg = 1; ern0 = 5'd9;
        tick;
        n_cmp++;
        if (malu !== 32'hFFFF_FFFA || mrn !== 5'd9 || mwreg !== 1'b1) begin
            n_fail++;
            $display("FAIL mflo got malu=%h mrn=%0d mwreg=%b expected fffffffa/9/1", malu, mrn, mwreg);
        end
        emdop = 3'b011;
        tick;
        n_cmp++;
        if (malu !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL mfhi got %h expected ffffffff", malu);
        end
    endtask

    task automatic test_div;
        int cyc, bad;
        idle_inputs;
        run_md(3'b010, 32'hFFFF_FFF9, 32'd2, cyc, bad);
        tick;
        n_cmp++;
        if (cyc !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_neg got cycles=%0d lo=%h hi=%h expected 33/fffffffd/ffffffff", cyc, lo, hi);
        end
        idle_inputs;
        run_md(3'b010, 32'd9, 32'd0, cyc, bad);
        tick;
        n_cmp++;
        if (cyc !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'd9) begin
            n_fail++;
            $display("FAIL div_zero got cycles=%0d lo=%h hi=%h expected 33/ffffffff/9", cyc, lo, hi);
        end
        idle_inputs;
        run_md(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bad);
        tick;
        n_cmp++;
        if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL div_overflow got lo=%h hi=%h expected 80000000/0", lo, hi);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc, bad;
        idle_inputs;
        emdop = 3'b010; ea = 32'd100; eb = 32'd7;
        for (int i = 0; i < 11; i++) tick;
        reset = 1; emdop = 3'b000;
        tick;
        reset = 0;
        #1;
        n_cmp++;
        if (stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_reset got stall=%b hi=%h lo=%h expected 0/0/0", stall, hi, lo);
        end
        for (int i = 0; i < 40; i++) tick;
        n_cmp++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_aborted got hi=%h lo=%h expected 0/0", hi, lo);
        end
        run_md(3'b001, 32'd7, 32'd6, cyc, bad);
        tick;
        n_cmp++;
        if (cyc !== 33 || lo !== 32'd42 || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_mult got cycles=%0d lo=%h hi=%h expected 33/2a/0", cyc, lo, hi);
        end
    endtask

    task automatic test_bubble;
        int cyc, bad, pulses;
        idle_inputs;
        ewmem = 1; ealuc = 4'b0000; ern0 = 5'd4;
        run_md(3'b001, 32'hFFFF_FFFE, 32'd3, cyc, bad);
        pulses = 0;
        tick;
        if (mwmem === 1'b1) pulses++;
        n_cmp++;
        if (bad !== 0 || mwmem !== 1'b1 || mb !== 32'd3) begin
            n_fail++;
            $display("FAIL bubble_store got bad=%0d mwmem=%b mb=%h expected 0/1/3", bad, mwmem, mb);
        end
        idle_inputs;
        tick;
        if (mwmem === 1'b1) pulses++;
        n_cmp++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL bubble_once got %0d store pulses expected 1", pulses);
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_shift_jal;
        test_mult;
        test_div;
        test_reset_mid_run;
        test_bubble;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline. Consumes the ID/EX register outputs and computes the ALU result.
- Contains an iterative signed multiply/divide unit with HI/LO registers. Stalls the front of the pipeline while that unit runs.
- Registers the results into the EX/MEM pipeline register feeding the memory stage.

Parameters:
- None. Datapath is fixed at 32 bits.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- ewreg  in  1  instruction writes GPR
- em2reg  in  1  GPR write data comes from memory
- ewmem  in  1  instruction writes memory
- ealuc  in  4  ALU operation code
- ealuimm  in  1  ALU operand B = eimm instead of eb
- ea  in  32  register operand A
- eb  in  32  register operand B / store data
- eimm  in  32  sign/zero-extended immediate
- ern0  in  5  destination register before jal override
- eshift  in  1  operand A = shamt, {27'b0, eimm[10:6]}
- ejal  in  1  jal: result = epc4+4, destination = 31
- epc4  in  32  PC+4 of the instruction
- emdop  in  3  000 none, 001 mult, 010 div, 011 mfhi, 100 mflo; others treated as none
- ern  out  5  combinational destination (ejal ? 31 : ern0), used for forwarding/hazard detection
- stall  out  1  combinational; holds PC, IF/ID and ID/EX
- mwreg, mm2reg, mwmem  out  1 each  registered controls
- malu  out  32  registered result
- mb  out  32  registered eb (store data)
- mrn  out  5  registered ern
- hi, lo  out  32 each  HI/LO contents, for debug

Behaviour:
- Reset: all registered outputs, HI, LO, FSM state and iteration counter are 0. FSM state is IDLE. Reset applied mid-operation aborts the operation; HI/LO are cleared, not updated.
- Operand A = eshift ? {27'b0, eimm[10:6]} : ea. Operand B = ealuimm ? eimm : eb.
- ALU codes (x = don't care):
  - x000 add, x100 sub, both wrap-around with no overflow trap
  - x001 and, x101 or, x010 xor
  - x110 lui: B << 16
  - 0011 sll: B << A[4:0]
  - 0111 srl: logical B >> A[4:0]
  - 1111 sra: arithmetic B >>> A[4:0]
- Result priority: ejal → epc4+4; else emdop=011 → HI; else emdop=100 → LO; else ALU result.
- Multiply/divide FSM states: IDLE, RUN, DONE.
  - IDLE with emdop in {001, 010}: stall=1. Latch operand magnitudes, result signs and op. Go to RUN with count=0.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle. Stays 32 cycles, count 0..31. After count=31, go to DONE.
  - DONE: stall=0. Apply sign correction. On this edge HI/LO are written and the FSM returns to IDLE.
  - Net effect: a mult/div occupies EX for 34 cycles, with stall=1 for the first 33.
- stall = (emdop in {001, 010}) && state != DONE.
- mult result: HI:LO = signed 64-bit product of ea*eb.
- div result: LO = quotient truncated toward zero; HI = remainder, which takes the dividend's sign.
- div boundary cases:
  - Divide by zero: LO=0xFFFFFFFF, HI=ea. Still takes full latency.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- EX/MEM register update, every non-reset edge:
  - stall=1: load a bubble. mwreg=mwmem=mm2reg=0; malu, mb, mrn = 0.
  - Otherwise: load the computed values.
- mult/div has ewreg=0 from decode, so its DONE cycle passes a non-writing entry.
- mfhi/mflo directly after a mult/div reads the new HI/LO. HI/LO are written on the DONE edge; the next instruction enters EX the following cycle.
- If emdop drops to none while in RUN (not legal from upstream): the FSM completes anyway and writes HI/LO; stall follows the formula.

Test Plan:
- Reset then ALU: ea=5, eb=3, ealuc=0100, emdop=0 → next edge malu=2, mrn=ern0, stall=0 throughout. Assert reset mid-stream → all outputs 0 on the next edge.
- Shifts and jal: eshift=1, eimm[10:6]=4, eb=0x80000000, ealuc=1111 → malu=0xF8000000. ejal=1, epc4=0x100 → malu=0x104, mrn=31.
- mult: ea=0xFFFFFFFE (-2), eb=3 → stall high exactly 33 cycles, mwreg=0 throughout, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Following mflo → malu=0xFFFFFFFA.
- div: ea=-7, eb=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Divide by zero with ea=9 → LO=0xFFFFFFFF, HI=9, same 34-cycle latency.
- Overflow divide: 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Reset at RUN count 10 → stall=0 next cycle, HI=LO=0, FSM IDLE.
- Bubble check: a store (ewmem=1) held in ID/EX behind a stalling mult never appears at mwmem until the stall drops; it then appears exactly once.
